// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU load path: default geometry, loader FSM states
// and the dimension check used when a load request is accepted.
package mpu_pkg;

  // Global defaults; modules expose these as overridable parameters
  localparam int DEFAULT_FP              = 32;
  localparam int DEFAULT_M               = 4;
  localparam int DEFAULT_N               = 4;
  localparam int DEFAULT_LANES           = 2;
  localparam int DEFAULT_MATRIX_REG_SIZE = 2;

  typedef enum logic [1:0] {
    LOAD_IDLE,
    LOAD_MATRIX,
    LOAD_DONE
  } load_state_t;

  function automatic logic dims_ok(input int m, input int n, input int max_m, input int max_n);
    return (m != 0) && (n != 0) && (m <= max_m) && (n <= max_n);
  endfunction

endpackage

// File: rtl/mpu_load_addr_gen.sv
// Row/column pointer for the matrix loader. Walks the source matrix row-major in
// groups of LANES columns; the last group of a row may be partial.
module mpu_load_addr_gen #(
  parameter int MW    = 3,
  parameter int NW    = 3,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [MW-1:0]    m_size,
  input  logic [NW-1:0]    n_size,
  output logic [MW-1:0]    row,
  output logic [NW-1:0]    col,
  output logic [LANES-1:0] lane_mask,
  output logic             last_beat
);

  // Two spare bits so col + LANES cannot wrap before the compare
  localparam int CW = NW + 2;

  logic [CW-1:0] col_next;
  logic          row_end;

  assign col_next  = CW'(col) + CW'(LANES);
  assign row_end   = col_next >= CW'(n_size);
  assign last_beat = row_end && (row == m_size - MW'(1));

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_mask[k] = (CW'(col) + CW'(k)) < CW'(n_size);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (row_end) begin
        col <= '0;
        row <= row + MW'(1);
      end else begin
        col <= col_next[NW-1:0];
      end
    end
  end

endmodule

// File: rtl/mpu_load_stream.sv
// Multi-lane matrix loader: streams row-major elements into the MPU register file.
// Optional transpose-on-load is enabled by defining MPU_LOAD_TRANSPOSE_EN.
module mpu_load_stream
  import mpu_pkg::*;
#(
  parameter  int FP              = DEFAULT_FP,
  parameter  int M               = DEFAULT_M,
  parameter  int N               = DEFAULT_N,
  parameter  int LANES           = DEFAULT_LANES,
  parameter  int MATRIX_REG_SIZE = DEFAULT_MATRIX_REG_SIZE,
  localparam int MBITS           = $clog2(M),
  localparam int NBITS           = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [MBITS:0]             matrix_m_size,
  input  logic [NBITS:0]             matrix_n_size,
  input  logic [MATRIX_REG_SIZE-1:0] load_addr,
  input  logic                       abort,
`ifdef MPU_LOAD_TRANSPOSE_EN
  input  logic                       transpose,
`endif
  input  logic                       elem_valid,
  output logic                       elem_ready,
  input  logic [LANES*FP-1:0]        element,
  output logic                       error,
  output logic                       done,
  output logic [LANES-1:0]           reg_load_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
  output logic [LANES*FP-1:0]        reg_element_out,
  output logic [MBITS:0]             reg_m_out,
  output logic [NBITS:0]             reg_n_out,
  output logic [MBITS:0]             reg_m_size,
  output logic [NBITS:0]             reg_n_size
);

  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;

  load_state_t state, state_next;

  logic [MW-1:0]    m_q;
  logic [NW-1:0]    n_q;
  logic             trans_q;
  logic             trans_in;
  logic             dims_valid;
  logic             start_fire;
  logic             beat_fire;
  logic             accept_start;
  logic [MW-1:0]    row;
  logic [NW-1:0]    col;
  logic [LANES-1:0] lane_mask;
  logic             last_beat;

`ifdef MPU_LOAD_TRANSPOSE_EN
  assign trans_in = transpose;
`else
  assign trans_in = 1'b0;
`endif

  // A transposed load lands as n x m, so the limits apply to the swapped shape
  assign dims_valid = trans_in ? dims_ok(int'(matrix_n_size), int'(matrix_m_size), M, N)
                               : dims_ok(int'(matrix_m_size), int'(matrix_n_size), M, N);

  assign start_ready  = (state == LOAD_IDLE);
  assign elem_ready   = (state == LOAD_MATRIX);
  assign start_fire   = start_valid && start_ready;
  assign accept_start = start_fire && dims_valid;
  assign beat_fire    = elem_valid && elem_ready && !abort;

  mpu_load_addr_gen #(
    .MW    (MW),
    .NW    (NW),
    .LANES (LANES)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept_start),
    .advance   (beat_fire),
    .m_size    (m_q),
    .n_size    (n_q),
    .row       (row),
    .col       (col),
    .lane_mask (lane_mask),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD_IDLE:   if (accept_start) state_next = LOAD_MATRIX;
      LOAD_MATRIX: begin
        if (abort)                       state_next = LOAD_IDLE;
        else if (beat_fire && last_beat) state_next = LOAD_DONE;
      end
      LOAD_DONE:   state_next = LOAD_IDLE;
      default:     state_next = LOAD_IDLE;
    endcase
  end

  // Iteration dims stay in source order; only the reported shape is swapped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q             <= '0;
      n_q             <= '0;
      trans_q         <= 1'b0;
      error           <= 1'b0;
      done            <= 1'b0;
      reg_load_en     <= '0;
      reg_load_addr   <= '0;
      reg_element_out <= '0;
      reg_m_out       <= '0;
      reg_n_out       <= '0;
      reg_m_size      <= '0;
      reg_n_size      <= '0;
    end else begin
      reg_load_en <= '0;
      done        <= (state == LOAD_DONE);
      if (start_fire) begin
        error <= !dims_valid;
        if (dims_valid) begin
          m_q           <= matrix_m_size;
          n_q           <= matrix_n_size;
          trans_q       <= trans_in;
          reg_load_addr <= load_addr;
          reg_m_size    <= trans_in ? MW'(matrix_n_size) : matrix_m_size;
          reg_n_size    <= trans_in ? NW'(matrix_m_size) : matrix_n_size;
        end
      end
      if (beat_fire) begin
        reg_load_en     <= lane_mask;
        reg_element_out <= element;
        reg_m_out       <= trans_q ? MW'(col) : row;
        reg_n_out       <= trans_q ? NW'(row) : col;
      end
    end
  end

endmodule
